// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM encoding, bit-order and parity constants, tick width.
// Common to the TX serializer and the RX analyser so both sides agree on framing.
package uart_pkg;

  typedef enum logic [6:0] {
    IDLE      = 7'b000_0001,
    FETCH     = 7'b000_0010,
    LOAD      = 7'b000_0100,
    STARTBIT  = 7'b000_1000,
    DATABITS  = 7'b001_0000,
    PARITYBIT = 7'b010_0000,
    STOPBIT   = 7'b100_0000
  } state_t;

  localparam logic BIGEND    = 1'b1;
  localparam logic LITTLEEND = 1'b0;

  localparam int BIT_TICKS = 16;

  localparam logic RIGHT = 1'b0;
  localparam logic WRONG = 1'b1;

  function automatic logic [7:0] bit_reverse(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/tx_shift_register.sv
// 8-bit parallel-load, MSB-first serial-out register with a count of shifts since load.
// Latency: load/shift take effect on the next edge; no backpressure, load wins over shift.
module tx_shift_register (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] par_dat,
  output logic       ser_dat,
  output logic [3:0] bit_cnt
);

  logic [7:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= par_dat;
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= {sr[6:0], 1'b0};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  assign ser_dat = sr[7];

endmodule

// File: rtl/uart_tx_byte_serializer.sv
// UART TX byte engine: FIFO read, start/8 data/optional even parity/stop framing onto TxD_o.
// Latency 2 clks + next tick to start edge; FIFO read only when p_empty_i low. TX_TWO_STOP_BITS_EN = 2 stop bits.
module uart_tx_byte_serializer
  import uart_pkg::*;
#(
  parameter int BIT_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic [7:0] data_i,
  input  logic       p_empty_i,
  output logic       n_re_o,
  input  logic       p_ParityEnable_i,
  input  logic       p_BigEnd_i,
  output logic       TxD_o,
  output logic [6:0] State_o,
  output logic [3:0] BitWidthCnt_o,
  output logic       p_Busy_o,
  output logic       p_TxDone_o
);

  localparam logic [3:0] BIT_LAST = 4'(BIT_TICKS - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       loaded;
  logic       parity_q;
  logic       par_en_q;
  logic       bit_end;
  logic       stop_done;
  logic       sr_load;
  logic       sr_shift;
  logic       sr_dat;
  logic [3:0] sr_cnt;
  logic [7:0] load_dat;
`ifdef TX_TWO_STOP_BITS_EN
  logic       second_stop;
`endif

  assign bit_end  = AcqSig_i && (cnt == BIT_LAST);
  // The first-sent bit always sits in the register MSB, whatever the bit order.
  assign load_dat = (p_BigEnd_i == BIGEND) ? data_i : bit_reverse(data_i);
  assign sr_load  = (state == LOAD) && !loaded;
  assign sr_shift = bit_end && ((state == STARTBIT) || ((state == DATABITS) && (sr_cnt != 4'd8)));

`ifdef TX_TWO_STOP_BITS_EN
  assign stop_done = bit_end && (state == STOPBIT) && second_stop;
`else
  assign stop_done = bit_end && (state == STOPBIT);
`endif

  tx_shift_register u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (sr_load),
    .shift   (sr_shift),
    .par_dat (load_dat),
    .ser_dat (sr_dat),
    .bit_cnt (sr_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      loaded      <= 1'b0;
      parity_q    <= 1'b0;
      par_en_q    <= 1'b0;
      TxD_o       <= 1'b1;
      n_re_o      <= 1'b1;
      p_Busy_o    <= 1'b0;
      p_TxDone_o  <= 1'b0;
`ifdef TX_TWO_STOP_BITS_EN
      second_stop <= 1'b0;
`endif
    end else begin
      n_re_o     <= 1'b1;
      p_TxDone_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!p_empty_i) begin
            state    <= FETCH;
            n_re_o   <= 1'b0;
            p_Busy_o <= 1'b1;
          end
        end
        FETCH: begin
          state  <= LOAD;
          loaded <= 1'b0;
        end
        LOAD: begin
          // Frame options are frozen on the cycle the read data arrives.
          if (!loaded) begin
            loaded   <= 1'b1;
            parity_q <= ^data_i;
            par_en_q <= p_ParityEnable_i;
          end
          if (AcqSig_i) begin
            state <= STARTBIT;
            cnt   <= '0;
            TxD_o <= 1'b0;
          end
        end
        STARTBIT, DATABITS, PARITYBIT, STOPBIT: begin
          if (AcqSig_i) cnt <= bit_end ? 4'd0 : cnt + 4'd1;
          if (bit_end) begin
            case (state)
              STARTBIT: begin
                state <= DATABITS;
                TxD_o <= sr_dat;
              end
              DATABITS: begin
                if (sr_cnt != 4'd8) begin
                  TxD_o <= sr_dat;
                end else if (par_en_q) begin
                  state <= PARITYBIT;
                  TxD_o <= parity_q;
                end else begin
                  state <= STOPBIT;
                  TxD_o <= 1'b1;
                end
              end
              PARITYBIT: begin
                state <= STOPBIT;
                TxD_o <= 1'b1;
              end
              STOPBIT: begin
`ifdef TX_TWO_STOP_BITS_EN
                second_stop <= !second_stop;
`endif
                if (stop_done) begin
                  p_TxDone_o <= 1'b1;
                  if (!p_empty_i) begin
                    state  <= FETCH;
                    n_re_o <= 1'b0;
                  end else begin
                    state    <= IDLE;
                    p_Busy_o <= 1'b0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        default: begin
          state    <= IDLE;
          TxD_o    <= 1'b1;
          p_Busy_o <= 1'b0;
        end
      endcase
    end
  end

  assign State_o       = state;
  assign BitWidthCnt_o = cnt;

endmodule

// File: tb/tb_uart_tx_byte_serializer.sv
// Scoreboard bench for uart_tx_byte_serializer: FIFO model feeds bytes, a line monitor
// decodes frames from TxD_o and compares them against frames computed from the byte and options.
`timescale 1ns/1ps
module tb_uart_tx_byte_serializer;

  localparam int TICK = 3;
`ifdef TX_TWO_STOP_BITS_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif
  localparam logic [6:0] ST_IDLE     = 7'b000_0001;
  localparam logic [6:0] ST_STARTBIT = 7'b000_1000;
  localparam logic [6:0] ST_DATABITS = 7'b001_0000;
  localparam logic [6:0] ST_PARITY   = 7'b010_0000;
  localparam logic [6:0] ST_STOPBIT  = 7'b100_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       AcqSig_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       p_empty_i = 1'b1;
  logic       n_re_o;
  logic       p_ParityEnable_i = 1'b0;
  logic       p_BigEnd_i = 1'b0;
  logic       TxD_o;
  logic [6:0] State_o;
  logic [3:0] BitWidthCnt_o;
  logic       p_Busy_o;
  logic       p_TxDone_o;

  uart_tx_byte_serializer #(.BIT_TICKS(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .AcqSig_i         (AcqSig_i),
    .data_i           (data_i),
    .p_empty_i        (p_empty_i),
    .n_re_o           (n_re_o),
    .p_ParityEnable_i (p_ParityEnable_i),
    .p_BigEnd_i       (p_BigEnd_i),
    .TxD_o            (TxD_o),
    .State_o          (State_o),
    .BitWidthCnt_o    (BitWidthCnt_o),
    .p_Busy_o         (p_Busy_o),
    .p_TxDone_o       (p_TxDone_o)
  );

  typedef struct {
    logic [7:0] dat;
    logic       pe;
    logic       big;
  } fifo_ent_t;

  typedef struct {
    logic [11:0] bits;
    int          len;
  } frame_t;

  fifo_ent_t fifo_q[$];
  frame_t    exp_q[$];
  int checks = 0;
  int passes = 0;
  int reads = 0;
  int dones = 0;
  int mon_clk = 0;
  int last_done_clk = -1;
  bit burst = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
  endtask

  // Line image of one frame, bit i = level of the i-th bit period after the start edge.
  function automatic frame_t model(input logic [7:0] d, input logic pe, input logic big);
    frame_t f;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = big ? d[7-i] : d[i];
    f.len = 9;
    if (pe) begin
      f.bits[9] = ^d;
      f.len     = 10;
    end
    f.len = f.len + STOPS;
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input logic pe, input logic big);
    fifo_ent_t e;
    e.dat = d;
    e.pe  = pe;
    e.big = big;
    fifo_q.push_back(e);
    exp_q.push_back(model(d, pe, big));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && State_o == ST_IDLE && p_empty_i) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(n < budget), 1);
  endtask

  // Oversample tick: one clock high every TICK clocks.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1 AcqSig_i = (ph == 0);
      ph = (ph + 1) % TICK;
    end
  end

  // FIFO model: read data and frame options appear after the read strobe;
  // options are scrambled mid-frame to show they are latched at LOAD.
  initial begin
    fifo_ent_t e;
    bit prev_re_low;
    prev_re_low = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && (State_o == ST_STARTBIT || State_o == ST_DATABITS || State_o == ST_PARITY || State_o == ST_STOPBIT)) begin
        p_ParityEnable_i = 1'($urandom_range(0, 1));
        p_BigEnd_i       = 1'($urandom_range(0, 1));
      end
      if (rst && !n_re_o) begin
        reads++;
        check("n_re_width", int'(prev_re_low), 0);
        check("read_nonempty", int'(fifo_q.size() > 0), 1);
        if (fifo_q.size() > 0) begin
          e = fifo_q.pop_front();
          data_i           = e.dat;
          p_ParityEnable_i = e.pe;
          p_BigEnd_i       = e.big;
        end
      end
      prev_re_low = rst && !n_re_o;
      p_empty_i = (fifo_q.size() == 0);
    end
  end

  // Line monitor: one sample per tick from the start edge until p_TxDone_o.
  initial begin
    bit          in_frame;
    bit          prev_txd;
    logic        samples[$];
    frame_t      e;
    logic [11:0] obs;
    int          bad;
    in_frame = 1'b0;
    prev_txd = 1'b1;
    forever begin
      @(negedge clk);
      mon_clk++;
      if (!rst) begin
        in_frame = 1'b0;
        prev_txd = 1'b1;
        samples.delete();
      end else begin
        if (in_frame && AcqSig_i) samples.push_back(TxD_o);
        if (p_TxDone_o) begin
          dones++;
          last_done_clk = mon_clk;
          check("done_in_frame", int'(in_frame), 1);
          if (in_frame) begin
            in_frame = 1'b0;
            check("frame_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("frame_ticks", samples.size(), e.len * 16);
              obs = '1;
              bad = 0;
              for (int i = 0; i < e.len; i++) begin
                obs[i] = (i * 16 < samples.size()) ? samples[i*16] : 1'b0;
                for (int j = 0; j < 16; j++)
                  if (i * 16 + j < samples.size() && samples[i*16+j] !== samples[i*16]) bad++;
              end
              check("bit_stable", bad, 0);
              check("frame_bits", int'(obs), int'(e.bits));
            end
          end
        end
        if (!in_frame && prev_txd && !TxD_o) begin
          in_frame = 1'b1;
          samples.delete();
          if (burst && last_done_clk >= 0)
            check("b2b_gap_ok", int'(mon_clk - last_done_clk <= TICK + 2), 1);
        end
        prev_txd = TxD_o;
      end
    end
  end

  initial begin
    int total;
    int r0;
    int low;
    int n;

    repeat (3) @(negedge clk);
    check("rst_txd", int'(TxD_o), 1);
    check("rst_n_re", int'(n_re_o), 1);
    check("rst_state", int'(State_o), int'(ST_IDLE));
    check("rst_bitcnt", int'(BitWidthCnt_o), 0);
    check("rst_busy", int'(p_Busy_o), 0);
    check("rst_done", int'(p_TxDone_o), 0);
    rst = 1'b1;
    @(negedge clk);

    send(8'h55, 1'b0, 1'b0);
    wait_idle(3000);
    check("reads_55", reads, 1);
    check("dones_55", dones, 1);
    send(8'h81, 1'b1, 1'b1);
    wait_idle(3000);
    send(8'h07, 1'b1, 1'b0);
    wait_idle(3000);
    send(8'hFF, 1'b0, 1'b0);
    wait_idle(3000);
    check("reads_directed", reads, 4);
    check("dones_directed", dones, 4);

    burst = 1'b1;
    last_done_clk = -1;
    send(8'h3C, 1'b1, 1'b0);
    send(8'hA7, 1'b0, 1'b1);
    send(8'h01, 1'b1, 1'b1);
    wait_idle(6000);
    burst = 1'b0;
    check("reads_burst", reads, 7);
    check("dones_burst", dones, 7);

    total = 7;
    for (int k = 0; k < 12; k++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      total++;
      repeat ($urandom_range(0, 700)) @(negedge clk);
    end
    wait_idle(20000);
    check("reads_random", reads, total);
    check("dones_random", dones, total);
    check("idle_txd", int'(TxD_o), 1);
    check("idle_busy", int'(p_Busy_o), 0);

    send(8'hA5, 1'b0, 1'b0);
    n = 0;
    while (State_o != ST_DATABITS && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_databits", int'(n < 3000), 1);
    repeat (72 * TICK) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_txd", int'(TxD_o), 1);
    check("midrst_state", int'(State_o), int'(ST_IDLE));
    check("midrst_busy", int'(p_Busy_o), 0);
    check("midrst_bitcnt", int'(BitWidthCnt_o), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    r0 = reads;
    low = 0;
    repeat (300) begin
      @(negedge clk);
      if (!TxD_o) low++;
    end
    check("postrst_reads", reads, r0);
    check("postrst_line_low", low, 0);
    check("postrst_state", int'(State_o), int'(ST_IDLE));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
